// File: rtl/soc_data_bus_demux.sv
// CPU data-port demux: routes requests to SRAM, peripheral window, tohost register or unmapped.
// Optional feature macro DATA_BUS_ACCESS_CNT_EN adds read/write access counters above tohost.
module soc_data_bus_demux #(
  parameter logic [31:0] SramBase      = 32'h8000_0000,
  parameter logic [31:0] SramSize      = 32'h0040_0000,
  parameter logic [31:0] PeriphBase    = 32'h0000_2000,
  parameter logic [31:0] PeriphSize    = 32'h0000_0100,
  parameter logic [31:0] TohostAddr    = 32'h0000_3000,
  parameter logic [31:0] UnmappedRdata = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  output logic        cpu_gnt_o,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [31:0] cpu_strb_i,
  input  logic        cpu_we_i,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  output logic        sram_req_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  output logic [31:0] sram_strb_o,
  output logic        sram_we_o,
  input  logic [31:0] sram_rdata_i,
  output logic        periph_req_o,
  output logic [31:0] periph_addr_o,
  output logic [31:0] periph_wdata_o,
  output logic [31:0] periph_strb_o,
  output logic        periph_we_o,
  input  logic        periph_gnt_i,
  input  logic [31:0] periph_rdata_i,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
  output logic        unmapped_err_o
);

`ifdef DATA_BUS_ACCESS_CNT_EN
  typedef enum logic [2:0] {
    SEL_SRAM, SEL_PERIPH, SEL_TOHOST, SEL_UNMAP, SEL_CNT_RD, SEL_CNT_WR
  } sel_e;
  localparam logic [31:0] CntRdAddr = TohostAddr + 32'd4;
  localparam logic [31:0] CntWrAddr = TohostAddr + 32'd8;
`else
  typedef enum logic [1:0] {SEL_SRAM, SEL_PERIPH, SEL_TOHOST, SEL_UNMAP} sel_e;
`endif

  // Window test done in 33 bits so a window near the top of memory cannot wrap.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return ({1'b0, addr} >= {1'b0, base}) && (off < {1'b0, size});
  endfunction

  sel_e        sel;
  logic        accept;
  logic        rvalid_q, rvalid_d;
  sel_e        rsel_q, rsel_d;
  logic        rwe_q, rwe_d;
  logic [31:0] tohost_q, tohost_d, tohost_merged;
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] rdata_mux;

  always_comb begin
    sel = SEL_UNMAP;
    if (cpu_addr_i[31:2] == TohostAddr[31:2]) sel = SEL_TOHOST;
    else if (in_window(cpu_addr_i, PeriphBase, PeriphSize)) sel = SEL_PERIPH;
    else if (in_window(cpu_addr_i, SramBase, SramSize)) sel = SEL_SRAM;
`ifdef DATA_BUS_ACCESS_CNT_EN
    else if (cpu_addr_i[31:2] == CntRdAddr[31:2]) sel = SEL_CNT_RD;
    else if (cpu_addr_i[31:2] == CntWrAddr[31:2]) sel = SEL_CNT_WR;
`endif
  end

  assign cpu_gnt_o      = ~rst_i & ((sel == SEL_PERIPH) ? periph_gnt_i : 1'b1);
  assign accept         = cpu_req_i & cpu_gnt_o;

  assign sram_req_o     = ~rst_i & cpu_req_i & (sel == SEL_SRAM);
  assign sram_addr_o    = cpu_addr_i;
  assign sram_wdata_o   = cpu_wdata_i;
  assign sram_strb_o    = cpu_strb_i;
  assign sram_we_o      = cpu_we_i;
  assign periph_req_o   = ~rst_i & cpu_req_i & (sel == SEL_PERIPH);
  assign periph_addr_o  = cpu_addr_i;
  assign periph_wdata_o = cpu_wdata_i;
  assign periph_strb_o  = cpu_strb_i;
  assign periph_we_o    = cpu_we_i;

  always_comb begin
    rvalid_d       = accept;
    rsel_d         = rsel_q;
    rwe_d          = rwe_q;
    tohost_d       = tohost_q;
    tohost_valid_d = tohost_valid_q;
    tohost_merged  = (tohost_q & ~cpu_strb_i) | (cpu_wdata_i & cpu_strb_i);
    if (accept) begin
      rsel_d = sel;
      rwe_d  = cpu_we_i;
    end
    // Once a non-zero value has landed, tohost is frozen.
    if (accept && cpu_we_i && (sel == SEL_TOHOST) && !tohost_valid_q) begin
      tohost_d       = tohost_merged;
      tohost_valid_d = (tohost_merged != 32'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q       <= 1'b0;
      rsel_q         <= SEL_SRAM;
      rwe_q          <= 1'b0;
      tohost_q       <= 32'd0;
      tohost_valid_q <= 1'b0;
    end else begin
      rvalid_q       <= rvalid_d;
      rsel_q         <= rsel_d;
      rwe_q          <= rwe_d;
      tohost_q       <= tohost_d;
      tohost_valid_q <= tohost_valid_d;
    end
  end

`ifdef DATA_BUS_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, cnt_rdata_q, cnt_rdata_d;

  // Counter reads return the value before this access's own increment.
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    cnt_rdata_d = cnt_rdata_q;
    if (accept) begin
      cnt_rdata_d = (sel == SEL_CNT_WR) ? wr_cnt_q : rd_cnt_q;
      if (!cpu_we_i) begin
        if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
      end else if (sel == SEL_CNT_RD) begin
        rd_cnt_d = 32'd0;
      end else if (sel == SEL_CNT_WR) begin
        wr_cnt_d = 32'd0;
      end else if (wr_cnt_q != 32'hFFFF_FFFF) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q    <= 32'd0;
      wr_cnt_q    <= 32'd0;
      cnt_rdata_q <= 32'd0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      cnt_rdata_q <= cnt_rdata_d;
    end
  end
`endif

  always_comb begin
    rdata_mux = 32'd0;
    case (rsel_q)
      SEL_SRAM:   rdata_mux = sram_rdata_i;
      SEL_PERIPH: rdata_mux = periph_rdata_i;
      SEL_TOHOST: rdata_mux = tohost_q;
      SEL_UNMAP:  rdata_mux = UnmappedRdata;
`ifdef DATA_BUS_ACCESS_CNT_EN
      SEL_CNT_RD, SEL_CNT_WR: rdata_mux = cnt_rdata_q;
`endif
      default:    rdata_mux = 32'd0;
    endcase
  end

  // Gating with rst_i squashes a response already registered when reset arrives.
  assign cpu_rvalid_o   = rvalid_q & ~rst_i;
  assign cpu_rdata_o    = (cpu_rvalid_o & ~rwe_q) ? rdata_mux : 32'd0;
  assign unmapped_err_o = cpu_rvalid_o & (rsel_q == SEL_UNMAP);
  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_q;

endmodule

// File: tb/tb_soc_data_bus_demux.sv
// Self-checking bench for soc_data_bus_demux: directed scenarios plus randomized traffic
// checked against an address-map reference model.
module tb_soc_data_bus_demux;
  localparam int T_SRAM = 0, T_PERIPH = 1, T_TOHOST = 2, T_UNMAP = 3, T_CNT_RD = 4, T_CNT_WR = 5;
`ifdef DATA_BUS_ACCESS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_i, rst_i;
  logic        cpu_req_i, cpu_gnt_o, cpu_we_i, cpu_rvalid_o;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_strb_i, cpu_rdata_o;
  logic        sram_req_o, sram_we_o;
  logic [31:0] sram_addr_o, sram_wdata_o, sram_strb_o, sram_rdata_i;
  logic        periph_req_o, periph_we_o, periph_gnt_i;
  logic [31:0] periph_addr_o, periph_wdata_o, periph_strb_o, periph_rdata_i;
  logic        tohost_valid_o, unmapped_err_o;
  logic [31:0] tohost_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_tohost, m_rd, m_wr;
  bit          m_valid;

  soc_data_bus_demux dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_gnt_o(cpu_gnt_o), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_strb_i(cpu_strb_i), .cpu_we_i(cpu_we_i),
    .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .sram_req_o(sram_req_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_strb_o(sram_strb_o), .sram_we_o(sram_we_o), .sram_rdata_i(sram_rdata_i),
    .periph_req_o(periph_req_o), .periph_addr_o(periph_addr_o),
    .periph_wdata_o(periph_wdata_o), .periph_strb_o(periph_strb_o),
    .periph_we_o(periph_we_o), .periph_gnt_i(periph_gnt_i), .periph_rdata_i(periph_rdata_i),
    .tohost_valid_o(tohost_valid_o), .tohost_data_o(tohost_data_o),
    .unmapped_err_o(unmapped_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic int model_target(input logic [31:0] a);
    longint unsigned x;
    x = {32'd0, a};
    if ((a & 32'hFFFF_FFFC) == 32'h0000_3000) return T_TOHOST;
    if (x >= 64'h2000 && x < 64'h2100) return T_PERIPH;
    if (x >= 64'h8000_0000 && x < 64'h8040_0000) return T_SRAM;
    if (CNT_EN && (a & 32'hFFFF_FFFC) == 32'h0000_3004) return T_CNT_RD;
    if (CNT_EN && (a & 32'hFFFF_FFFC) == 32'h0000_3008) return T_CNT_WR;
    return T_UNMAP;
  endfunction

  task automatic apply_reset();
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; periph_gnt_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    m_tohost = 32'd0; m_valid = 1'b0; m_rd = 32'd0; m_wr = 32'd0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1 cpu_req_i = 1'b1; cpu_addr_i = 32'h8000_0000; cpu_we_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (cpu_gnt_o !== 1'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0", cpu_gnt_o); end
    n_cmp++; if (sram_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_sram_req: got %b want 0", sram_req_o); end
    n_cmp++; if (cpu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", cpu_rvalid_o); end
    n_cmp++; if (cpu_rdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata_o); end
    n_cmp++; if (tohost_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_tohost_valid: got %b want 0", tohost_valid_o); end
    n_cmp++; if (tohost_data_o !== 32'd0) begin n_bad++; $display("FAIL reset_tohost_data: got %h want 0", tohost_data_o); end
    n_cmp++; if (unmapped_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", unmapped_err_o); end
    @(posedge clk_i);
    #1 rst_i = 1'b0; cpu_req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_no_resp: got %b want 0", cpu_rvalid_o); end
  endtask

  task automatic test_sram_read();
    @(posedge clk_i);
    #1 cpu_req_i = 1'b1; cpu_addr_i = 32'h8000_0010; cpu_we_i = 1'b0; sram_rdata_i = 32'd0;
    @(negedge clk_i);
    n_cmp++; if (sram_req_o !== 1'b1) begin n_bad++; $display("FAIL sram_req: got %b want 1", sram_req_o); end
    n_cmp++; if (sram_addr_o !== 32'h8000_0010) begin n_bad++; $display("FAIL sram_addr: got %h want 80000010", sram_addr_o); end
    n_cmp++; if (periph_req_o !== 1'b0) begin n_bad++; $display("FAIL sram_periph_req: got %b want 0", periph_req_o); end
    n_cmp++; if (cpu_gnt_o !== 1'b1) begin n_bad++; $display("FAIL sram_gnt: got %b want 1", cpu_gnt_o); end
    @(posedge clk_i);
    #1 cpu_req_i = 1'b0; sram_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL sram_rvalid: got %b want 1", cpu_rvalid_o); end
    n_cmp++; if (cpu_rdata_o !== 32'h1234_5678) begin n_bad++; $display("FAIL sram_rdata: got %h want 12345678", cpu_rdata_o); end
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL sram_single_resp: got %b want 0", cpu_rvalid_o); end
  endtask

  task automatic test_periph_wait();
    @(posedge clk_i);
    #1 cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_2008; cpu_we_i = 1'b0; periph_gnt_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) begin @(posedge clk_i); #1; end
      @(negedge clk_i);
      n_cmp++; if (cpu_gnt_o !== 1'b0) begin n_bad++; $display("FAIL periph_wait_gnt[%0d]: got %b want 0", c, cpu_gnt_o); end
      n_cmp++; if (periph_req_o !== 1'b1) begin n_bad++; $display("FAIL periph_wait_req[%0d]: got %b want 1", c, periph_req_o); end
      n_cmp++; if (cpu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL periph_wait_rvalid[%0d]: got %b want 0", c, cpu_rvalid_o); end
    end
    @(posedge clk_i);
    #1 periph_gnt_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (cpu_gnt_o !== 1'b1) begin n_bad++; $display("FAIL periph_gnt: got %b want 1", cpu_gnt_o); end
    @(posedge clk_i);
    #1 cpu_req_i = 1'b0; periph_gnt_i = 1'b0; periph_rdata_i = 32'hCAFE_0008;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL periph_rvalid: got %b want 1", cpu_rvalid_o); end
    n_cmp++; if (cpu_rdata_o !== 32'hCAFE_0008) begin n_bad++; $display("FAIL periph_rdata: got %h want cafe0008", cpu_rdata_o); end
  endtask

  task automatic test_unmapped();
    @(posedge clk_i);
    #1 cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0000; cpu_we_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (sram_req_o !== 1'b0 || periph_req_o !== 1'b0) begin n_bad++; $display("FAIL unmap_req: got %b%b want 00", sram_req_o, periph_req_o); end
    @(posedge clk_i);
    #1 cpu_addr_i = 32'hFFFF_FFFC; sram_rdata_i = 32'h1111_1111;
    @(negedge clk_i);
    n_cmp++; if (cpu_rdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL unmap0_rdata: got %h want deadbeef", cpu_rdata_o); end
    n_cmp++; if (unmapped_err_o !== 1'b1) begin n_bad++; $display("FAIL unmap0_err: got %b want 1", unmapped_err_o); end
    n_cmp++; if (sram_req_o !== 1'b0) begin n_bad++; $display("FAIL unmap_top_nowrap: got %b want 0", sram_req_o); end
    @(posedge clk_i);
    #1 cpu_addr_i = 32'h0000_1000; cpu_we_i = 1'b1; cpu_wdata_i = 32'h5555_AAAA; cpu_strb_i = '1;
    @(negedge clk_i);
    n_cmp++; if (cpu_rdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL unmap_top_rdata: got %h want deadbeef", cpu_rdata_o); end
    n_cmp++; if (unmapped_err_o !== 1'b1) begin n_bad++; $display("FAIL unmap_top_err: got %b want 1", unmapped_err_o); end
    @(posedge clk_i);
    #1 cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'd0) begin n_bad++; $display("FAIL unmap_wr_resp: got %b/%h want 1/0", cpu_rvalid_o, cpu_rdata_o); end
    n_cmp++; if (unmapped_err_o !== 1'b1) begin n_bad++; $display("FAIL unmap_wr_err: got %b want 1", unmapped_err_o); end
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    n_cmp++; if (unmapped_err_o !== 1'b0) begin n_bad++; $display("FAIL unmap_err_pulse: got %b want 0", unmapped_err_o); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk_i);
    #1 cpu_req_i = 1'b1; cpu_addr_i = 32'h8000_0020; cpu_we_i = 1'b0;
    @(posedge clk_i);
    #1 cpu_addr_i = 32'h0000_2010; periph_gnt_i = 1'b1; sram_rdata_i = 32'hA1A1_A1A1; periph_rdata_i = 32'd0;
    @(negedge clk_i);
    n_cmp++; if (cpu_gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt: got %b want 1", cpu_gnt_o); end
    n_cmp++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'hA1A1_A1A1) begin n_bad++; $display("FAIL b2b_first: got %b/%h want 1/a1a1a1a1", cpu_rvalid_o, cpu_rdata_o); end
    @(posedge clk_i);
    #1 cpu_req_i = 1'b0; periph_gnt_i = 1'b0; periph_rdata_i = 32'hB2B2_B2B2; sram_rdata_i = 32'd0;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'hB2B2_B2B2) begin n_bad++; $display("FAIL b2b_second: got %b/%h want 1/b2b2b2b2", cpu_rvalid_o, cpu_rdata_o); end
    @(posedge clk_i);
    #1 cpu_req_i = 1'b1; cpu_addr_i = 32'h8000_0024;
    @(posedge clk_i);
    #1 cpu_addr_i = 32'h0000_2014; periph_gnt_i = 1'b1; sram_rdata_i = 32'hC3C3_C3C3;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'hC3C3_C3C3) begin n_bad++; $display("FAIL b2b_pre_rst: got %b/%h want 1/c3c3c3c3", cpu_rvalid_o, cpu_rdata_o); end
    @(posedge clk_i);
    #1 cpu_req_i = 1'b0; periph_gnt_i = 1'b0; rst_i = 1'b1; periph_rdata_i = 32'hD4D4_D4D4;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_squash: got %b want 0", cpu_rvalid_o); end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    m_tohost = 32'd0; m_valid = 1'b0; m_rd = 32'd0; m_wr = 32'd0;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_after_rst: got %b want 0", cpu_rvalid_o); end
  endtask

  task automatic test_counters();
    logic [31:0] ca [9];
    bit          cw [9];
    apply_reset();
    ca = '{32'h8000_0000, 32'h8000_0004, 32'h0000_2000, 32'h8000_0008, 32'h8000_000C,
           32'h0000_3004, 32'h0000_3008, 32'h0000_3004, 32'h0000_3004};
    cw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    periph_gnt_i = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      @(posedge clk_i);
      #1;
      if (i < 9) begin
        cpu_req_i = 1'b1; cpu_addr_i = ca[i]; cpu_we_i = cw[i];
        cpu_wdata_i = 32'h0000_00FF; cpu_strb_i = '1;
      end else begin
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
      end
      @(negedge clk_i);
      if (i == 6 || i == 7 || i == 9) begin
        logic [31:0] want;
        want = (i == 6) ? (CNT_EN ? 32'd3 : 32'hDEAD_BEEF) :
               (i == 7) ? (CNT_EN ? 32'd2 : 32'hDEAD_BEEF) : (CNT_EN ? 32'd0 : 32'hDEAD_BEEF);
        n_cmp++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== want) begin n_bad++; $display("FAIL cnt_read[%0d]: got %b/%h want 1/%h", i - 1, cpu_rvalid_o, cpu_rdata_o, want); end
        n_cmp++; if (unmapped_err_o !== !CNT_EN) begin n_bad++; $display("FAIL cnt_err[%0d]: got %b want %b", i - 1, unmapped_err_o, !CNT_EN); end
      end
    end
    periph_gnt_i = 1'b0;
  endtask

  task automatic test_tohost();
    @(posedge clk_i);
    #1 cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_3000; cpu_we_i = 1'b1; cpu_wdata_i = 32'd0; cpu_strb_i = '1;
    @(posedge clk_i);
    #1 cpu_wdata_i = 32'h0000_0001;
    @(negedge clk_i);
    n_cmp++; if (tohost_valid_o !== 1'b0) begin n_bad++; $display("FAIL tohost_zero_write: got %b want 0", tohost_valid_o); end
    n_cmp++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'd0) begin n_bad++; $display("FAIL tohost_wr_resp: got %b/%h want 1/0", cpu_rvalid_o, cpu_rdata_o); end
    @(posedge clk_i);
    #1 cpu_wdata_i = 32'h0000_0005;
    @(negedge clk_i);
    n_cmp++; if (tohost_valid_o !== 1'b1) begin n_bad++; $display("FAIL tohost_valid: got %b want 1", tohost_valid_o); end
    n_cmp++; if (tohost_data_o !== 32'd1) begin n_bad++; $display("FAIL tohost_data: got %h want 1", tohost_data_o); end
    @(posedge clk_i);
    #1 cpu_we_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (tohost_data_o !== 32'd1) begin n_bad++; $display("FAIL tohost_frozen: got %h want 1", tohost_data_o); end
    @(posedge clk_i);
    #1 cpu_req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'd1) begin n_bad++; $display("FAIL tohost_read: got %b/%h want 1/1", cpu_rvalid_o, cpu_rdata_o); end
  endtask

  task automatic test_random();
    logic [31:0] edges [8];
    bit          pv, pw, acc, exp_gnt;
    int          pt, tgt;
    logic [31:0] pc, want;
    edges = '{32'h803F_FFFC, 32'h8040_0000, 32'h0000_20FC, 32'h0000_2100,
              32'h0000_1FFC, 32'hFFFF_FFFC, 32'h7FFF_FFFC, 32'h0000_300C};
    apply_reset();
    pv = 1'b0; pw = 1'b0; pt = T_UNMAP; pc = 32'd0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk_i);
      #1;
      cpu_req_i = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 6))
        0: cpu_addr_i = 32'h8000_0000 | ($urandom & 32'h003F_FFFF);
        1: cpu_addr_i = 32'h0000_2000 | ($urandom & 32'h0000_00FF);
        2: cpu_addr_i = 32'h0000_3000 | ($urandom & 32'h3);
        3: cpu_addr_i = 32'h0000_3004;
        4: cpu_addr_i = 32'h0000_3008;
        5: cpu_addr_i = $urandom;
        default: cpu_addr_i = edges[$urandom_range(0, 7)];
      endcase
      cpu_we_i       = $urandom_range(0, 1);
      cpu_wdata_i    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cpu_strb_i     = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
      periph_gnt_i   = ($urandom_range(0, 2) != 0);
      sram_rdata_i   = $urandom;
      periph_rdata_i = $urandom;
      @(negedge clk_i);
      tgt     = model_target(cpu_addr_i);
      exp_gnt = (tgt == T_PERIPH) ? periph_gnt_i : 1'b1;
      acc     = cpu_req_i && exp_gnt;
      n_cmp++; if (cpu_gnt_o !== exp_gnt) begin n_bad++; $display("FAIL rnd_gnt@%0d addr %h: got %b want %b", c, cpu_addr_i, cpu_gnt_o, exp_gnt); end
      n_cmp++; if (sram_req_o !== (cpu_req_i && tgt == T_SRAM)) begin n_bad++; $display("FAIL rnd_sram_req@%0d addr %h: got %b", c, cpu_addr_i, sram_req_o); end
      n_cmp++; if (periph_req_o !== (cpu_req_i && tgt == T_PERIPH)) begin n_bad++; $display("FAIL rnd_periph_req@%0d addr %h: got %b", c, cpu_addr_i, periph_req_o); end
      if (cpu_req_i && tgt == T_SRAM) begin
        n_cmp++; if (sram_addr_o !== cpu_addr_i || sram_wdata_o !== cpu_wdata_i || sram_strb_o !== cpu_strb_i || sram_we_o !== cpu_we_i) begin n_bad++; $display("FAIL rnd_sram_pass@%0d: got %h/%h/%h/%b", c, sram_addr_o, sram_wdata_o, sram_strb_o, sram_we_o); end
      end
      if (cpu_req_i && tgt == T_PERIPH) begin
        n_cmp++; if (periph_addr_o !== cpu_addr_i || periph_wdata_o !== cpu_wdata_i || periph_strb_o !== cpu_strb_i || periph_we_o !== cpu_we_i) begin n_bad++; $display("FAIL rnd_periph_pass@%0d: got %h/%h/%h/%b", c, periph_addr_o, periph_wdata_o, periph_strb_o, periph_we_o); end
      end
      want = 32'd0;
      if (pv && !pw) begin
        case (pt)
          T_SRAM:   want = sram_rdata_i;
          T_PERIPH: want = periph_rdata_i;
          T_TOHOST: want = m_tohost;
          T_UNMAP:  want = 32'hDEAD_BEEF;
          default:  want = pc;
        endcase
      end
      n_cmp++; if (cpu_rvalid_o !== pv) begin n_bad++; $display("FAIL rnd_rvalid@%0d: got %b want %b", c, cpu_rvalid_o, pv); end
      n_cmp++; if (cpu_rdata_o !== want) begin n_bad++; $display("FAIL rnd_rdata@%0d tgt %0d: got %h want %h", c, pt, cpu_rdata_o, want); end
      n_cmp++; if (unmapped_err_o !== (pv && pt == T_UNMAP)) begin n_bad++; $display("FAIL rnd_err@%0d: got %b", c, unmapped_err_o); end
      n_cmp++; if (tohost_valid_o !== m_valid || tohost_data_o !== m_tohost) begin n_bad++; $display("FAIL rnd_tohost@%0d: got %b/%h want %b/%h", c, tohost_valid_o, tohost_data_o, m_valid, m_tohost); end
      pv = acc; pw = cpu_we_i; pt = tgt; pc = 32'd0;
      if (acc) begin
        if (cpu_we_i) begin
          if (tgt == T_TOHOST && !m_valid) begin
            m_tohost = (m_tohost & ~cpu_strb_i) | (cpu_wdata_i & cpu_strb_i);
            m_valid  = (m_tohost != 32'd0);
          end
          if (tgt == T_CNT_RD) m_rd = 32'd0;
          else if (tgt == T_CNT_WR) m_wr = 32'd0;
          else if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 32'd1;
        end else begin
          pc = (tgt == T_CNT_WR) ? m_wr : m_rd;
          if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 32'd1;
        end
      end
    end
    cpu_req_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'd0;
    cpu_wdata_i = 32'd0; cpu_strb_i = 32'd0; periph_gnt_i = 1'b0;
    sram_rdata_i = 32'd0; periph_rdata_i = 32'd0;
    m_tohost = 32'd0; m_valid = 1'b0; m_rd = 32'd0; m_wr = 32'd0;
    test_reset();
    test_sram_read();
    test_periph_wait();
    test_unmapped();
    test_back_to_back();
    test_counters();
    test_tohost();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
